operand_fetch_stage: RTL and testbench

- Second pipeline stage of the accumulator processor, directly downstream of the instruction-fetch stage register (5-bit opcode, 3-bit address mode, 8-bit data field).
- Resolves the addressing mode into a final 8-bit operand and effective address, issuing up to two data-memory reads.
- Hands the result to the execute/accumulator stage over a valid/ready handshake.
- Supports flush on interrupt.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/ea_calc.sv | 17 +
 rtl/operand_fetch_stage.sv | 91 +++++++++
 tb/tb_operand_fetch_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, address-mode codes and operand-fetch state encoding.
package cpu_pkg;
    localparam int DATA_W = 8;
    localparam int OPC_W  = 5;
    localparam int MODE_W = 3;
    localparam logic [MODE_W-1:0] AM_IMM = 3'b000;
    localparam logic [MODE_W-1:0] AM_DIR = 3'b001;
    localparam logic [MODE_W-1:0] AM_IND = 3'b010;
    localparam logic [MODE_W-1:0] AM_IDX = 3'b011;
    localparam logic [MODE_W-1:0] AM_IMP = 3'b100;
    typedef enum logic [2:0] {S_IDLE, S_RD1, S_WT1, S_RD2, S_WT2, S_OUT} of_state_t;
endpackage

// File: rtl/ea_calc.sv
// ea_calc: decodes an address mode into read count, first read address and illegal flag.
module ea_calc
    import cpu_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] index,
    output logic [1:0]        rd_cnt,
    output logic [DATA_W-1:0] addr,
    output logic              illegal
);
    always_comb begin
        rd_cnt  = (mode == AM_DIR || mode == AM_IDX) ? 2'd1 : (mode == AM_IND) ? 2'd2 : 2'd0;
        addr    = (mode == AM_IDX) ? data + index : data;
        illegal = mode > AM_IMP;
    end
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: resolves the address mode into operand and effective address,
// issuing up to two data-memory reads, and hands the bundle to execute.
module operand_fetch_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] index_reg,
    input  logic              flush,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [OPC_W-1:0]  ex_opcode,
    output logic [DATA_W-1:0] ex_operand,
    output logic [DATA_W-1:0] ex_ea,
    output logic              ex_illegal
);
    of_state_t         state, state_nx;
    logic [OPC_W-1:0]  opcode_q;
    logic [DATA_W-1:0] operand_q, ea_q, addr_q, first_addr;
    logic [1:0]        rd_cnt;
    logic              two_q, illegal_q, illegal_d, accept;

    ea_calc u_ea (
        .mode    (in_mode),
        .data    (in_data),
        .index   (index_reg),
        .rd_cnt  (rd_cnt),
        .addr    (first_addr),
        .illegal (illegal_d)
    );

    assign accept = state == S_IDLE && in_valid && !flush;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = in_valid ? (rd_cnt == 2'd0 ? S_OUT : S_RD1) : S_IDLE;
            S_RD1:   state_nx = S_WT1;
            S_WT1:   state_nx = two_q ? S_RD2 : S_OUT;
            S_RD2:   state_nx = S_WT2;
            S_WT2:   state_nx = S_OUT;
            S_OUT:   state_nx = ex_ready ? S_IDLE : S_OUT;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
        in_ready   = state == S_IDLE;
        ex_valid   = state == S_OUT;
        mem_rd_en  = state == S_RD1 || state == S_RD2;
        ex_illegal = ex_valid && illegal_q;
        mem_addr   = addr_q;
        ex_opcode  = opcode_q;
        ex_operand = operand_q;
        ex_ea      = ea_q;
    end

    // For indirect mode the first read returns the effective address, which is also the second read target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_q  <= '0;
            operand_q <= '0;
            ea_q      <= '0;
            addr_q    <= '0;
            two_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            opcode_q  <= in_opcode;
            operand_q <= in_mode == AM_IMM ? in_data : '0;
            ea_q      <= in_mode == AM_IMM ? in_data : (rd_cnt != 2'd0 ? first_addr : '0);
            two_q     <= rd_cnt == 2'd2;
            illegal_q <= illegal_d;
            if (rd_cnt != 2'd0) addr_q <= first_addr;
        end else if (!flush && state == S_WT1 && two_q) begin
            ea_q   <= mem_rdata;
            addr_q <= mem_rdata;
        end else if (!flush && (state == S_WT1 || state == S_WT2)) begin
            operand_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: scoreboard bench with a behavioural memory and address-mode model.
module tb_operand_fetch_stage;
    import cpu_pkg::*;

    logic              clk = 1'b0, reset = 1'b0, in_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
    logic [OPC_W-1:0]  in_opcode = '0;
    logic [MODE_W-1:0] in_mode = '0;
    logic [DATA_W-1:0] in_data = '0, index_reg = '0, mem_rdata = '0;
    logic              in_ready, mem_rd_en, ex_valid, ex_illegal;
    logic [DATA_W-1:0] mem_addr, ex_operand, ex_ea;
    logic [OPC_W-1:0]  ex_opcode;

    typedef struct {
        logic [4:0] opc;
        logic [7:0] operand;
        logic [7:0] ea;
        logic       ill;
        int         lat;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] mem[256];
    int         total = 0, bad = 0, cyc = 0, stall_cnt = 0;
    bit         held = 0;
    exp_t       cur;

    operand_fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .index_reg  (index_reg),
        .flush      (flush),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_opcode  (ex_opcode),
        .ex_operand (ex_operand),
        .ex_ea      (ex_ea),
        .ex_illegal (ex_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic [4:0] opc, input logic [2:0] mode, input logic [7:0] data,
                         input logic [7:0] idx, output exp_t e);
        int n = 0;
        int a;
        e.opc = opc; e.operand = 8'h00; e.ea = 8'h00; e.ill = 1'b0;
        case (mode)
            3'd0: begin e.operand = data; e.ea = data; end
            3'd1: begin e.ea = data; rd_q.push_back(data); n = 1; end
            3'd2: begin rd_q.push_back(data); e.ea = mem[data]; rd_q.push_back(e.ea); n = 2; end
            3'd3: begin a = (int'(data) + int'(idx)) % 256; e.ea = a[7:0]; rd_q.push_back(e.ea); n = 1; end
            3'd4: e.ill = 1'b0;
            default: e.ill = 1'b1;
        endcase
        if (n > 0) e.operand = mem[e.ea];
        e.lat = 1 + 2 * n;
        e.acc = cyc + 1;
    endtask

    always @(negedge clk) begin
        if (mem_rd_en) begin
            chk("rd_expected", 32'(rd_q.size() != 0), 1);
            if (rd_q.size() != 0) chk("rd_addr", mem_addr, rd_q.pop_front());
        end
        if (ex_valid) begin
            chk("busy_in_ready", in_ready, 0);
            if (!held) begin
                chk("exp_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    held = 1;
                    chk("latency", cyc - cur.acc + 1, cur.lat);
                end
            end
            if (held) begin
                chk("opcode", ex_opcode, cur.opc);
                chk("operand", ex_operand, cur.operand);
                chk("ea", ex_ea, cur.ea);
                chk("illegal", ex_illegal, cur.ill);
            end
            ex_ready = stall_cnt == 0;
            if (stall_cnt > 0) stall_cnt--;
        end else begin
            held = 0;
            ex_ready = 1'b0;
        end
    end

    task automatic issue(input logic [4:0] opc, input logic [2:0] mode, input logic [7:0] data,
                         input logic [7:0] idx, input int stall);
        exp_t e;
        int t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        chk("accept_ready", in_ready, 1);
        model(opc, mode, data, idx, e);
        exp_q.push_back(e);
        stall_cnt = stall;
        in_opcode = opc; in_mode = mode; in_data = data; index_reg = idx; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_opcode = 5'($urandom); in_mode = 3'($urandom); in_data = 8'($urandom); index_reg = 8'($urandom);
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 100) begin @(negedge clk); t++; end
        chk("handoff_done", 32'(t < 100), 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_operand", ex_operand, 0);
        chk("rst_ea", ex_ea, 0);
        chk("rst_opcode", ex_opcode, 0);
        chk("rst_illegal", ex_illegal, 0);
        reset = 1'b1;
        @(negedge clk);

        mem[8'h10] = 8'h77; mem[8'h20] = 8'h40; mem[8'h40] = 8'h99;
        issue(5'h03, 3'b000, 8'h5A, 8'h00, 0);
        issue(5'h04, 3'b001, 8'h10, 8'h00, 1);
        issue(5'h05, 3'b010, 8'h20, 8'h00, 0);
        mem[8'h10] = 8'h33;
        issue(5'h06, 3'b011, 8'hF0, 8'h20, 4);
        issue(5'h07, 3'b110, 8'hAB, 8'h00, 0);
        issue(5'h08, 3'b111, 8'hFF, 8'h00, 2);
        issue(5'h09, 3'b100, 8'h3C, 8'h00, 0);
        issue(5'h0A, 3'b001, 8'hFF, 8'h00, 0);

        // flush during WT1 of an indirect op: only the first read may appear
        rd_q.push_back(8'h20);
        in_opcode = 5'h0B; in_mode = 3'b010; in_data = 8'h20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_ex_valid", ex_valid, 0);
        repeat (6) @(negedge clk);
        chk("flush_quiet", ex_valid, 0);

        // flush wins over a simultaneous accept
        in_opcode = 5'h0C; in_mode = 3'b000; in_data = 8'h11; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_idle", in_ready, 1);
        chk("flush_accept_valid", ex_valid, 0);
        issue(5'h0D, 3'b001, 8'h10, 8'h00, 0);

        for (int i = 0; i < 200; i++) begin
            mem[8'($urandom)] = 8'($urandom);
            issue(5'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        // async reset between edges while in RD2
        rd_q.push_back(8'h20);
        in_opcode = 5'h0E; in_mode = 3'b010; in_data = 8'h20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("ar_in_ready", in_ready, 1);
        chk("ar_ex_valid", ex_valid, 0);
        chk("ar_mem_rd_en", mem_rd_en, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(5'h0F, 3'b000, 8'hC3, 8'h00, 1);

        repeat (3) @(negedge clk);
        chk("leftover_exp", exp_q.size(), 0);
        chk("leftover_rd", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
